// File: rtl/pd_debug_cnt_bank.sv
// PD debug counter bank: accumulates dbg2cif event pulses into saturating packet/byte counters,
// latches the captured PD word and serves everything through a registered read req/ack port.
module pd_debug_cnt_bank #(
    parameter int unsigned CNT_WIDTH         = 32,
    parameter int unsigned BYTE_CNT_WIDTH    = 48,
    parameter int unsigned PACKET_SIZE_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
    input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
    input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
    input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
    input  logic                         dbg2cif_e_debug_pd_capture_match_field2,
    input  logic [31:0]                  dbg2cif_c_debug_pd_out,
    input  logic                         cif_cnt_freeze,
    input  logic                         cif_rd_req,
    input  logic [3:0]                   cif_rd_addr,
    input  logic                         cif_rd_clr,
    output logic                         cif_rd_ack,
    output logic [31:0]                  cif_rd_data,
    output logic [5:0]                   cnt_sat_o
);

    localparam int unsigned HiWidth = BYTE_CNT_WIDTH - 32;

    typedef enum logic {StIdle, StResp} rd_state_e;

    rd_state_e                 state_q, state_d;
    logic                      rd_accept;
    logic                      ack_q;
    logic [31:0]               rd_data_q, rd_data_d, rd_mux;
    logic [CNT_WIDTH-1:0]      pkt_cnt_q [4];
    logic [CNT_WIDTH-1:0]      pkt_cnt_d [4];
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q [2];
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt_d [2];
    logic [HiWidth-1:0]        shadow_q [2];
    logic [HiWidth-1:0]        shadow_d [2];
    logic [31:0]               cap_word_q, cap_word_d;
    logic [1:0]                cap_flags_q, cap_flags_d;
    logic [5:0]                sat_q, sat_d, new_sat;
    logic [3:0]                pkt_inc;
    logic [1:0]                byte_inc;
    logic [CNT_WIDTH:0]        pkt_sum;
    logic [BYTE_CNT_WIDTH:0]   byte_sum;
    logic                      lo_rd;

    always_comb begin
        rd_accept = 1'b0;
        state_d   = state_q;
        case (state_q)
            StIdle: begin
                if (cif_rd_req) begin
                    rd_accept = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (cif_rd_addr)
            4'd0:    rd_mux = 32'(pkt_cnt_q[0]);
            4'd1:    rd_mux = 32'(pkt_cnt_q[1]);
            4'd2:    rd_mux = 32'(pkt_cnt_q[2]);
            4'd3:    rd_mux = 32'(pkt_cnt_q[3]);
            4'd4:    rd_mux = byte_cnt_q[0][31:0];
            4'd5:    rd_mux = 32'(shadow_q[0]);
            4'd6:    rd_mux = byte_cnt_q[1][31:0];
            4'd7:    rd_mux = 32'(shadow_q[1]);
            4'd8:    rd_mux = cap_word_q;
            4'd9:    rd_mux = 32'(cap_flags_q);
            4'd10:   rd_mux = 32'(sat_q);
            default: rd_mux = '0;
        endcase
        rd_data_d = rd_accept ? rd_mux : rd_data_q;
    end

    always_comb begin
        pkt_inc  = {dbg2cif_e_debug_pd_total_pd_cnt_inc, dbg2cif_e_debug_pd_capture_match_cnt_inc,
                    dbg2cif_e_debug_pd_field2_cnt_inc, dbg2cif_e_debug_pd_field1_cnt_inc}
                   & {4{~cif_cnt_freeze}};
        byte_inc = {dbg2cif_e_debug_pd_field2_byte_cnt_inc, dbg2cif_e_debug_pd_field1_byte_cnt_inc}
                   & {2{~cif_cnt_freeze}};
        new_sat  = '0;
        pkt_sum  = '0;
        byte_sum = '0;
        lo_rd    = 1'b0;

        for (int i = 0; i < 4; i++) begin
            pkt_sum      = {1'b0, pkt_cnt_q[i]} + {{CNT_WIDTH{1'b0}}, 1'b1};
            pkt_cnt_d[i] = pkt_cnt_q[i];
            // A clear racing an increment keeps the increment.
            if (rd_accept && cif_rd_clr && cif_rd_addr == 4'(i)) begin
                pkt_cnt_d[i] = CNT_WIDTH'(pkt_inc[i]);
            end else if (pkt_inc[i]) begin
                if (pkt_sum[CNT_WIDTH]) begin
                    pkt_cnt_d[i] = '1;
                    new_sat[i]   = 1'b1;
                end else begin
                    pkt_cnt_d[i] = pkt_sum[CNT_WIDTH-1:0];
                end
            end
        end

        for (int i = 0; i < 2; i++) begin
            byte_sum      = {1'b0, byte_cnt_q[i]}
                            + (BYTE_CNT_WIDTH+1)'(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount);
            lo_rd         = rd_accept && cif_rd_addr == 4'(4 + 2 * i);
            // Snapshot the upper bits so a later hi read matches this lo read.
            shadow_d[i]   = lo_rd ? byte_cnt_q[i][BYTE_CNT_WIDTH-1:32] : shadow_q[i];
            byte_cnt_d[i] = byte_cnt_q[i];
            if (lo_rd && cif_rd_clr) begin
                byte_cnt_d[i] = byte_inc[i]
                    ? BYTE_CNT_WIDTH'(dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount) : '0;
            end else if (byte_inc[i]) begin
                if (byte_sum[BYTE_CNT_WIDTH]) begin
                    byte_cnt_d[i] = '1;
                    new_sat[4+i]  = 1'b1;
                end else begin
                    byte_cnt_d[i] = byte_sum[BYTE_CNT_WIDTH-1:0];
                end
            end
        end

        sat_d = ((rd_accept && cif_rd_clr && cif_rd_addr == 4'd10) ? 6'd0 : sat_q) | new_sat;

        cap_word_d  = cap_word_q;
        cap_flags_d = cap_flags_q;
        if (pkt_inc[2]) begin
            cap_word_d  = dbg2cif_c_debug_pd_out;
            cap_flags_d = {dbg2cif_e_debug_pd_capture_match_field2,
                           dbg2cif_e_debug_pd_capture_match_field1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            ack_q       <= 1'b0;
            rd_data_q   <= '0;
            cap_word_q  <= '0;
            cap_flags_q <= '0;
            sat_q       <= '0;
            for (int i = 0; i < 4; i++) pkt_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                byte_cnt_q[i] <= '0;
                shadow_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            ack_q       <= rd_accept;
            rd_data_q   <= rd_data_d;
            cap_word_q  <= cap_word_d;
            cap_flags_q <= cap_flags_d;
            sat_q       <= sat_d;
            for (int i = 0; i < 4; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
            for (int i = 0; i < 2; i++) begin
                byte_cnt_q[i] <= byte_cnt_d[i];
                shadow_q[i]   <= shadow_d[i];
            end
        end
    end

    assign cif_rd_ack  = ack_q;
    assign cif_rd_data = rd_data_q;
    assign cnt_sat_o   = sat_q;

endmodule

// File: tb/tb_pd_debug_cnt_bank.sv
// Scoreboard bench for pd_debug_cnt_bank: a reference model pushes expected read data at request
// acceptance; a monitor pops and compares whenever the DUT acknowledges.
module tb_pd_debug_cnt_bank;

    localparam int unsigned CW = 4;
    localparam int unsigned BW = 36;
    localparam int unsigned PW = 24;
    localparam logic [BW:0] BMAX = {1'b0, {BW{1'b1}}};

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [5:0]    incs = '0;
    logic [PW-1:0] amount = '0;
    logic          cap_f1 = 1'b0, cap_f2 = 1'b0;
    logic [31:0]   pd_word = '0;
    logic          freeze = 1'b0, rd_req = 1'b0, rd_clr = 1'b0;
    logic [3:0]    rd_addr = '0;
    logic          rd_ack;
    logic [31:0]   rd_data;
    logic [5:0]    sat;

    always #5 clk = ~clk;

    pd_debug_cnt_bank #(
        .CNT_WIDTH(CW),
        .BYTE_CNT_WIDTH(BW),
        .PACKET_SIZE_WIDTH(PW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .dbg2cif_e_debug_pd_field1_cnt_inc(incs[0]),
        .dbg2cif_e_debug_pd_field2_cnt_inc(incs[1]),
        .dbg2cif_e_debug_pd_capture_match_cnt_inc(incs[2]),
        .dbg2cif_e_debug_pd_total_pd_cnt_inc(incs[3]),
        .dbg2cif_e_debug_pd_field1_byte_cnt_inc(incs[4]),
        .dbg2cif_e_debug_pd_field2_byte_cnt_inc(incs[5]),
        .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount(amount),
        .dbg2cif_e_debug_pd_capture_match_field1(cap_f1),
        .dbg2cif_e_debug_pd_capture_match_field2(cap_f2),
        .dbg2cif_c_debug_pd_out(pd_word),
        .cif_cnt_freeze(freeze),
        .cif_rd_req(rd_req),
        .cif_rd_addr(rd_addr),
        .cif_rd_clr(rd_clr),
        .cif_rd_ack(rd_ack),
        .cif_rd_data(rd_data),
        .cnt_sat_o(sat)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  addr;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [31:0]   last_rd = '0;

    logic [CW-1:0] m_cnt [4];
    logic [BW-1:0] m_byte [2];
    logic [BW-33:0] m_hi [2];
    logic [31:0]   m_word;
    logic [1:0]    m_flags;
    logic [5:0]    m_sat;
    bit            m_busy;
    bit            rand_mode = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        for (int j = 0; j < 2; j++) begin
            m_byte[j] = '0;
            m_hi[j]   = '0;
        end
        m_word  = '0;
        m_flags = '0;
        m_sat   = '0;
        m_busy  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return 32'(m_cnt[0]);
            4'd1:    return 32'(m_cnt[1]);
            4'd2:    return 32'(m_cnt[2]);
            4'd3:    return 32'(m_cnt[3]);
            4'd4:    return m_byte[0][31:0];
            4'd5:    return 32'(m_hi[0]);
            4'd6:    return m_byte[1][31:0];
            4'd7:    return 32'(m_hi[1]);
            4'd8:    return m_word;
            4'd9:    return 32'(m_flags);
            4'd10:   return 32'(m_sat);
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by the inputs currently driven, then let the DUT take the same edge.
    task automatic tick();
        bit          acc;
        logic [5:0]  ns;
        logic [BW:0] s;
        bit          act;
        if (rand_mode) begin
            incs    = 6'($urandom);
            amount  = PW'($urandom);
            pd_word = $urandom;
            cap_f1  = 1'($urandom);
            cap_f2  = 1'($urandom);
            freeze  = ($urandom_range(0, 7) == 0);
        end
        acc = rstn && rd_req && !m_busy;
        if (!rstn) begin
            model_reset();
        end else begin
            if (acc) begin
                last_rd = model_read(rd_addr);
                exp_q.push_back('{last_rd, rd_addr});
            end
            ns = '0;
            for (int i = 0; i < 4; i++) begin
                act = incs[i] && !freeze;
                if (acc && rd_clr && rd_addr == 4'(i)) m_cnt[i] = CW'(act);
                else if (act) begin
                    if (m_cnt[i] == {CW{1'b1}}) ns[i] = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1'b1;
                end
            end
            for (int j = 0; j < 2; j++) begin
                act = incs[4+j] && !freeze;
                if (acc && rd_addr == 4'(4 + 2 * j)) m_hi[j] = m_byte[j][BW-1:32];
                if (acc && rd_clr && rd_addr == 4'(4 + 2 * j)) begin
                    m_byte[j] = act ? BW'(amount) : '0;
                end else if (act) begin
                    s = {1'b0, m_byte[j]} + (BW+1)'(amount);
                    if (s > BMAX) begin
                        m_byte[j] = BMAX[BW-1:0];
                        ns[4+j]   = 1'b1;
                    end else begin
                        m_byte[j] = s[BW-1:0];
                    end
                end
            end
            if (incs[2] && !freeze) begin
                m_word  = pd_word;
                m_flags = {cap_f2, cap_f1};
            end
            m_sat  = ((acc && rd_clr && rd_addr == 4'd10) ? 6'd0 : m_sat) | ns;
            m_busy = acc;
        end
        @(posedge clk);
        #1;
        if (rstn) check_eq("sat", 64'(sat), 64'(m_sat));
    endtask

    task automatic do_read(input logic [3:0] a, input logic c);
        rd_req  = 1'b1;
        rd_addr = a;
        rd_clr  = c;
        tick();
        check_eq("ack_lat", 64'(rd_ack), 64'd1);
        rd_req = 1'b0;
        rd_clr = 1'b0;
        if (!rand_mode) incs = '0;
        tick();
        check_eq("ack_one", 64'(rd_ack), 64'd0);
        check_eq("data_hold", 64'(rd_data), 64'(last_rd));
    endtask

    task automatic pulse(input logic [5:0] m, input int n);
        incs = m;
        repeat (n) tick();
        incs = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ack", 64'(rd_ack), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq($sformatf("rd_addr%0d", mon_e.addr), 64'(rd_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held while every event pulses.
        incs   = '1;
        amount = 24'd5;
        repeat (3) tick();
        check_eq("rst_ack", 64'(rd_ack), 64'd0);
        check_eq("rst_data", 64'(rd_data), 64'd0);
        check_eq("rst_sat", 64'(sat), 64'd0);
        incs = '0;
        rstn = 1'b1;
        tick();
        for (int a = 0; a <= 10; a++) do_read(4'(a), 1'b0);

        // Counting: 5 total pulses, 3 of them alongside 100-byte field1 pulses.
        amount = 24'd100;
        pulse(6'b01_1000, 3);
        pulse(6'b00_1000, 2);
        do_read(4'd3, 1'b0);
        do_read(4'd4, 1'b0);
        do_read(4'd5, 1'b0);

        // Clear racing an increment.
        pulse(6'b00_0001, 7);
        incs = 6'b00_0001;
        do_read(4'd0, 1'b1);
        do_read(4'd0, 1'b0);

        // Packet saturation and sticky flag clear.
        pulse(6'b00_0010, 17);
        do_read(4'd1, 1'b0);
        do_read(4'd10, 1'b1);
        do_read(4'd10, 1'b0);

        // Capture, then a frozen capture that must be ignored.
        pd_word = 32'hA5A5_0001;
        cap_f2  = 1'b1;
        pulse(6'b00_0100, 1);
        freeze  = 1'b1;
        pd_word = 32'h1234_5678;
        cap_f1  = 1'b1;
        cap_f2  = 1'b0;
        pulse(6'b00_0100, 1);
        freeze  = 1'b0;
        do_read(4'd8, 1'b0);
        do_read(4'd9, 1'b0);
        do_read(4'd2, 1'b0);

        // Hi/lo coherence across the 32-bit boundary.
        amount = '1;
        pulse(6'b01_0000, 257);
        do_read(4'd4, 1'b0);
        pulse(6'b01_0000, 300);
        do_read(4'd5, 1'b0);
        do_read(4'd4, 1'b0);
        do_read(4'd5, 1'b0);

        // Byte counter saturation and full clear.
        pulse(6'b10_0000, 4100);
        do_read(4'd6, 1'b0);
        do_read(4'd7, 1'b0);
        do_read(4'd10, 1'b0);
        do_read(4'd6, 1'b1);
        do_read(4'd6, 1'b0);

        // Freeze blocks increments but not clear-on-read.
        freeze = 1'b1;
        pulse(6'b11_1111, 3);
        do_read(4'd3, 1'b1);
        do_read(4'd3, 1'b0);
        freeze = 1'b0;

        // Request held high: only every other edge may accept.
        rd_req  = 1'b1;
        rd_addr = 4'd8;
        repeat (5) tick();
        rd_req = 1'b0;
        tick();

        // Randomised traffic with reads of every address.
        rand_mode = 1'b1;
        repeat (150) begin
            repeat ($urandom_range(0, 3)) tick();
            do_read(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        incs      = '0;
        freeze    = 1'b0;
        tick();
        tick();
        check_eq("pending", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pd_debug_cnt_bank.md
# pd_debug_cnt_bank

- Sits on the CIF side of the PD debug path and consumes the `dbg2cif_*` event pulses produced by the PD debug matcher.
- Accumulates the events into packet and byte counters, latches the captured debug word and match flags, and serves all of it to software through a registered read request/acknowledge port.
- Supports clear-on-read, saturation and freeze.

## Interface
- `CNT_WIDTH`, 32, width of the four packet counters.
- `BYTE_CNT_WIDTH`, 48, width of the two byte counters (range 33..64).
- `PACKET_SIZE_WIDTH`, 14, width of the byte increment amount.
- `clk`  in  1  single clock; all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `dbg2cif_e_debug_pd_field1_cnt_inc`  in  1  field1 match pulse.
- `dbg2cif_e_debug_pd_field2_cnt_inc`  in  1  field2 match pulse.
- `dbg2cif_e_debug_pd_capture_match_cnt_inc`  in  1  capture match pulse; also the capture strobe.
- `dbg2cif_e_debug_pd_total_pd_cnt_inc`  in  1  valid-PD pulse.
- `dbg2cif_e_debug_pd_field1_byte_cnt_inc`  in  1  add amount to field1 byte counter.
- `dbg2cif_e_debug_pd_field2_byte_cnt_inc`  in  1  add amount to field2 byte counter.
- `dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount`  in  PACKET_SIZE_WIDTH  byte amount; shared by both byte counters.
- `dbg2cif_e_debug_pd_capture_match_field1`  in  1  field1 flag qualifying the capture.
- `dbg2cif_e_debug_pd_capture_match_field2`  in  1  field2 flag qualifying the capture.
- `dbg2cif_c_debug_pd_out`  in  32  selected PD word to capture.
- `cif_cnt_freeze`  in  1  level; while high, all increments and captures are ignored.
- `cif_rd_req`  in  1  read request, level.
- `cif_rd_addr`  in  4  register index.
- `cif_rd_clr`  in  1  clear-on-read qualifier, sampled with the request.
- `cif_rd_ack`  out  1  one-cycle read acknowledge.
- `cif_rd_data`  out  32  read data, valid while `cif_rd_ack`=1.
- `cnt_sat_o`  out  6  sticky saturation flags, in order: field1, field2, capture, total, field1_byte, field2_byte.

## Operation
Register map (narrower counters are zero-extended):
- 0: field1_cnt
- 1: field2_cnt
- 2: capture_match_cnt
- 3: total_pd_cnt
- 4: field1_byte lo[31:0]
- 5: field1_byte hi (shadow)
- 6: field2_byte lo[31:0]
- 7: field2_byte hi (shadow)
- 8: captured word
- 9: {30'b0, cap_f2, cap_f1}
- 10: {26'b0, cnt_sat_o}
- 11–15: read as 0

Counting:
- Each increment input acts independently; any combination may be high in the same cycle.
- Packet counters add 1; byte counters add the amount.
- Both byte counters may add the same amount in the same cycle.

Saturation:
- A counter saturates at all-ones; it never wraps.
- An increment that would overflow loads all-ones and sets the counter's `cnt_sat_o` bit.
- `cnt_sat_o` bits are sticky. They clear only on a read of addr 10 with `cif_rd_clr`=1.

Capture:
- When `capture_match_cnt_inc`=1 and freeze=0, `dbg2cif_c_debug_pd_out` and both match_field flags are latched into addr 8 and addr 9.
- The latched values replace the previous capture; they are not cleared by reads.

Freeze: with `cif_cnt_freeze`=1, counters, sat flags and capture registers hold. Reads and clears still operate.

Hi/lo coherence:
- A read of a lo address (4 or 6) copies the upper `BYTE_CNT_WIDTH-32` bits of that counter into its shadow at the same edge.
- Addr 5 and addr 7 return the shadow.

Clear-on-read:
- Applies to addresses 0–4, 6 and 10. Clearing a byte counter (addr 4 or 6) clears the entire counter.
- `cif_rd_clr` on any other address has no effect.
- Data returned is the pre-clear value.
- An increment on the same edge as a clear is not lost: the counter loads the increment value (1 or amount).

Read FSM, states IDLE and RESP:
- IDLE→RESP when `cif_rd_req`=1. Address and clr are sampled at that edge.
- RESP→IDLE unconditionally after one cycle.
- `cif_rd_req` high during RESP is ignored.
- The requester must hold req and addr until it sees ack, then drop req in the ack cycle. A req still high after RESP is accepted as a new read.

## Timing
- Reset values: all counters, shadows, capture registers and `cnt_sat_o` are 0; `cif_rd_ack`=0; `cif_rd_data`=0; FSM in IDLE.
- Reset asserted mid-read drops the transaction: no ack is issued.
- Read latency: request accepted at edge N gives `cif_rd_ack`=1 and data in cycle N..N+1, registered. Ack is high for exactly one cycle.
- `cif_rd_data` holds its last value after ack drops.
- Read data reflects all increments sampled at edges before N. It excludes an increment sampled at edge N itself, which lands in the counter, or in the post-clear value if cleared.
- Increment visibility: a pulse at edge N is readable by a request accepted at edge N+1 or later.
- `cnt_sat_o` updates at the same edge the saturating increment is sampled.
- Maximum throughput: one read every 2 cycles.

## Test plan
- Reset: apply `rstn`=0 while incrementing, release, then read addr 0–10 → every read returns 0 and `cnt_sat_o`=0.
- Counting: apply 5 total_pd pulses and 3 field1_byte pulses of amount 100 → addr 3 reads 5, addr 4 reads 300, addr 5 reads 0; ack arrives exactly 1 cycle after req.
- Hi/lo coherence: preload field1_byte to 0xFFFF_FFF0 (1 pulse of amount 0x3FFF repeated), read addr 4, add more bytes, then read addr 5 → addr 5 returns the hi value captured at the addr 4 read, not the live hi.
- Clear race: read addr 0 with `cif_rd_clr`=1 on the same edge as a field1 pulse, with the counter at 7 → data 7, next read returns 1.
- Saturation: with `CNT_WIDTH`=4, apply 17 field2 pulses → addr 1 reads 15, `cnt_sat_o[1]`=1; then read addr 10 with clr=1 → returns 0x2, flags then read 0.
- Capture and freeze: capture pulse with word 0xA5A5_0001 and field2=1, then with freeze=1 apply a capture pulse with word 0x1234_5678 → addr 8 reads 0xA5A5_0001, addr 9 reads 0x2, addr 2 reads 1.
